// File: rtl/uart_mmio_tx.sv
// uart_mmio_tx: MMIO-fed byte FIFO plus 8N1 UART transmitter; define UART_TX_PARITY_EN for 8E1 (even parity).
module uart_mmio_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        mmio_wea,
  input  logic [31:0] mmio_dat,
  output logic        mmio_read,
  output logic        tx_full,
  output logic        tx_busy,
  output logic        tx_ovf,
  output logic        tx
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state_q, state_d;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] data_q, data_d;
  logic tx_q, tx_d, read_q, full_q, full_d, busy_q, busy_d, ovf_q, ovf_d;
  logic push, pop, full, baud_end, unused_hi;
  assign unused_hi = ^mmio_dat[31:8];
  assign full = count_q == (AW+1)'(FIFO_DEPTH);
  assign baud_end = baud_q == CW'(CLKS_PER_BIT - 1);
  // tx_d is the line level of the current state; registering it keeps tx glitch-free
  always_comb begin
    push = mmio_wea && !full;
    pop = 1'b0;
    state_d = state_q;
    baud_d = baud_end ? '0 : baud_q + 1'b1;
    bit_d = bit_q;
    tx_d = 1'b1;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        pop = count_q != '0;
        state_d = pop ? START : IDLE;
      end
      START: begin
        tx_d = 1'b0;
        bit_d = '0;
        state_d = baud_end ? DATA : START;
      end
      DATA: begin
        tx_d = data_q[bit_q];
        bit_d = baud_end ? bit_q + 3'd1 : bit_q;
`ifdef UART_TX_PARITY_EN
        state_d = (baud_end && bit_q == 3'd7) ? PARITY : DATA;
      end
      PARITY: begin
        tx_d = ^data_q;
        state_d = baud_end ? STOP : PARITY;
`else
        state_d = (baud_end && bit_q == 3'd7) ? STOP : DATA;
`endif
      end
      STOP: begin
        pop = baud_end && count_q != '0;
        state_d = baud_end ? (pop ? START : IDLE) : STOP;
      end
      default: state_d = IDLE;
    endcase
    data_d = pop ? mem[rd_ptr_q] : data_q;
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    full_d = count_d == (AW+1)'(FIFO_DEPTH);
    busy_d = state_d != IDLE || count_d != '0;
    ovf_d = ovf_q || (mmio_wea && full);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr_q] <= mmio_dat[7:0];
  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      data_q <= '0;
      tx_q <= 1'b1;
      read_q <= 1'b0;
      full_q <= 1'b0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      data_q <= data_d;
      tx_q <= tx_d;
      read_q <= push;
      full_q <= full_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
  end
  assign tx = tx_q;
  assign mmio_read = read_q;
  assign tx_full = full_q;
  assign tx_busy = busy_q;
  assign tx_ovf = ovf_q;
endmodule
